// File: rtl/memory_pkg.sv
// memory_pkg: types shared by the cache and backing-store side of the memory link.
package memory_pkg;

    typedef enum logic [1:0] {
        MEM_OK,
        MEM_BUSY,
        MEM_ERROR
    } memory_status_t;

    typedef logic [1:0] bs_state_t;

    localparam bs_state_t BS_IDLE    = 2'd0;
    localparam bs_state_t BS_LATENCY = 2'd1;
    localparam bs_state_t BS_BURST   = 2'd2;

endpackage

// File: rtl/single_port_ram_sync.sv
// single_port_ram_sync: one read/write port, registered read, zero-initialised storage.
module single_port_ram_sync #(
  parameter int width = 16,
  parameter int depth = 4096,
  parameter init_file = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] addr,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata
);
  logic [width-1:0] mem [depth];
  initial for (int i = 0; i < depth; i++) mem[i] = '0;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/backing_store_responder.sv
// backing_store_responder: fixed-latency wrapping-burst responder standing in for DRAM.
// Beat k of a burst hits the critical word's aligned block at offset (low + k) mod burst_amount.
module backing_store_responder
    import memory_pkg::*;
#(
    parameter int word_size    = 2,
    parameter int word_count   = 4096,
    parameter int latency      = 3,
    parameter int burst_amount = 8,
    parameter init_file        = ""
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          backing_store_req,
    input  logic [$clog2(word_count)-1:0] backing_store_address,
    input  logic                          backing_store_we,
    input  logic [8*word_size-1:0]        backing_store_wdata,
    output logic                          backing_store_drdy,
    output logic [8*word_size-1:0]        backing_store_rdata,
    output logic                          backing_store_busy
);

    localparam int aw = $clog2(word_count);
    localparam int bw = $clog2(burst_amount);
    localparam int dw = 8 * word_size;

    bs_state_t         state;
    logic [3:0]        delay;
    logic [bw-1:0]     beat;
    logic [aw-1:0]     base;
    logic              we_q;
    logic              last;
    logic              accept;
    logic [bw-1:0]     next_beat;
    logic [aw-1:0]     cur_addr;
    logic [aw-1:0]     rd_addr;
    logic [aw-1:0]     ram_addr;
    logic              ram_we;
    logic [dw-1:0]     ram_q;

    always_comb begin
        last      = state == BS_BURST && beat == bw'(burst_amount - 1);
        backing_store_busy = state == BS_LATENCY || (state == BS_BURST && !last);
        accept    = backing_store_req && !backing_store_busy;
        backing_store_drdy = state == BS_BURST;
        next_beat = state == BS_BURST ? beat + 1'b1 : '0;
        cur_addr  = {base[aw-1:bw], base[bw-1:0] + beat};
        // The RAM read is registered, so it is issued one cycle ahead of the beat it serves.
        rd_addr   = accept ? backing_store_address : {base[aw-1:bw], base[bw-1:0] + next_beat};
        ram_we    = backing_store_drdy && we_q && !reset;
        ram_addr  = backing_store_drdy && we_q ? cur_addr : rd_addr;
        backing_store_rdata = backing_store_drdy && !we_q ? ram_q : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BS_IDLE;
            delay <= '0;
            beat  <= '0;
            base  <= '0;
            we_q  <= 1'b0;
        end else if (accept) begin
            base  <= backing_store_address;
            we_q  <= backing_store_we;
            beat  <= '0;
            delay <= 4'(latency - 1);
            state <= latency == 1 ? BS_BURST : BS_LATENCY;
        end else if (state == BS_LATENCY) begin
            delay <= delay - 1'b1;
            state <= delay == 4'd0 ? BS_BURST : BS_LATENCY;
        end else if (state == BS_BURST) begin
            beat  <= beat + 1'b1;
            state <= last ? BS_IDLE : BS_BURST;
        end
    end

    single_port_ram_sync #(
        .width     (dw),
        .depth     (word_count),
        .init_file (init_file)
    ) ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (backing_store_wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_backing_store_responder.sv
// tb_backing_store_responder: directed checks of burst timing, wrap order, busy drop and reset abort.
module tb_backing_store_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [11:0] address;
    logic        we;
    logic [15:0] wdata;
    logic        drdy;
    logic [15:0] rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [8];
    logic        next_we;
    logic [11:0] next_addr;

    backing_store_responder dut (
        .clk                   (clk),
        .reset                 (reset),
        .backing_store_req     (req),
        .backing_store_address (address),
        .backing_store_we      (we),
        .backing_store_wdata   (wdata),
        .backing_store_drdy    (drdy),
        .backing_store_rdata   (rdata),
        .backing_store_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // issue=0 continues a burst whose request was already sampled by a chained call.
    // inject drives a request to 0x100 at edge E+2; chain requests next_addr on the final beat;
    // abort>=0 raises reset at the edge ending that beat.
    task automatic run_burst(input logic w, input logic [11:0] a, input string tag,
                             input bit issue, input bit inject, input bit chain, input int abort);
        if (issue) begin
            req = 1'b1; we = w; address = a;
            step();
        end
        req = 1'b0; we = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s_lat%0d_drdy", tag, c), drdy, 0);
            chk($sformatf("%s_lat%0d_busy", tag, c), busy, 1);
            if (inject && c == 1) begin
                req = 1'b1; address = 12'h100;
            end
            step();
            req = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_b%0d_drdy", tag, k), drdy, 1);
            chk($sformatf("%s_b%0d_busy", tag, k), busy, k != 7);
            if (w) begin
                chk($sformatf("%s_b%0d_rdata_w", tag, k), rdata, 0);
                wdata = exp_q[k];
            end else
                chk($sformatf("%s_b%0d_rdata", tag, k), rdata, exp_q[k]);
            if (k == abort) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk({tag, "_rst_drdy"}, drdy, 0);
                chk({tag, "_rst_rdata"}, rdata, 0);
                chk({tag, "_rst_busy"}, busy, 0);
                return;
            end
            if (chain && k == 7) begin
                req = 1'b1; we = next_we; address = next_addr;
            end
            step();
        end
        if (!chain) begin
            chk({tag, "_end_drdy"}, drdy, 0);
            chk({tag, "_end_rdata"}, rdata, 0);
            chk({tag, "_end_busy"}, busy, 0);
        end
    endtask

    initial begin
        reset = 1'b1; req = 1'b1; we = 1'b0; address = 12'h010; wdata = '0;
        step();
        step();
        chk("rst_drdy", drdy, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0; req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle%0d_drdy", i), drdy, 0);
        end

        for (int k = 0; k < 8; k++) exp_q[k] = 16'h1000 + 16'(k);
        run_burst(1'b1, 12'h010, "wr010", 1, 0, 0, -1);
        run_burst(1'b0, 12'h010, "rd010", 1, 0, 0, -1);

        for (int k = 0; k < 8; k++) exp_q[k] = 16'h1000 + 16'((5 + k) % 8);
        run_burst(1'b0, 12'h015, "wrap015", 1, 0, 0, -1);

        for (int k = 0; k < 8; k++) exp_q[k] = 16'h1000 + 16'(k);
        run_burst(1'b0, 12'h010, "busydrop", 1, 1, 0, -1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("busydrop_quiet%0d", i), drdy, 0);
            step();
        end

        next_we = 1'b0; next_addr = 12'h012;
        run_burst(1'b0, 12'h010, "b2b_first", 1, 0, 1, -1);
        for (int k = 0; k < 8; k++) exp_q[k] = 16'h1000 + 16'((2 + k) % 8);
        run_burst(1'b0, 12'h012, "b2b_second", 0, 0, 0, -1);

        for (int k = 0; k < 8; k++) exp_q[k] = 16'hAAAA;
        run_burst(1'b1, 12'h020, "wrabort", 1, 0, 0, 4);
        for (int k = 0; k < 8; k++) exp_q[k] = k < 4 ? 16'hAAAA : 16'h0000;
        run_burst(1'b0, 12'h020, "rd020", 1, 0, 0, -1);

        for (int k = 0; k < 8; k++) exp_q[k] = 16'hF000 + 16'(k);
        run_burst(1'b1, 12'hFF8, "wrFF8", 1, 0, 0, -1);
        for (int k = 0; k < 8; k++) exp_q[k] = 16'hF000 + 16'((6 + k) % 8);
        run_burst(1'b0, 12'hFFE, "rdFFE", 1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
